// File: rtl/ahb_decoder_dp_pkg.sv
// Shared AHB-Lite types, the decoder memory map and the default-slave FSM states.
// Holds the AHB_package used by ahb_decoder_dp and ahb_default_slave.
package AHB_package;

  localparam int unsigned SLV_MAX = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    StIdle,
    StErr1,
    StErr2
  } dec_def_state_e;

  // Inclusive region bounds. Slave 2 sits inside slave 6 and wins there by lower index.
  // Unused entries have low > high so they never match.
  localparam logic [31:0] SLV_LOW [SLV_MAX] = '{
    32'h0000_0000, 32'h0000_1000, 32'h0001_8000, 32'h0000_3000,
    32'h0000_4000, 32'h0000_5000, 32'h0001_0000, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF
  };

  localparam logic [31:0] SLV_HIGH [SLV_MAX] = '{
    32'h0000_0FFF, 32'h0000_1FFF, 32'h0001_8FFF, 32'h0000_3FFF,
    32'h0000_4FFF, 32'h0000_5FFF, 32'h0001_FFFF, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000
  };

  // True for transfer types that carry data.
  function automatic logic trans_active(input htrans_type t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_decoder_dp_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR
// response and everything else with a zero-wait OKAY.
module ahb_default_slave
  import AHB_package::*;
(
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       hready,
  input  htrans_type htrans,
  input  logic       def_sel,
  output logic       def_hreadyout,
  output hresp_type  def_hresp
);

  dec_def_state_e state_q, state_d;
  logic           hreadyout_q, hreadyout_d;
  hresp_type      hresp_q, hresp_d;
  logic           err_start;

  assign err_start = hready && def_sel && trans_active(htrans);

  // Next state; outputs are registered from the state being entered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (err_start) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = err_start ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
    hreadyout_d = (state_d != StErr1);
    hresp_d     = (state_d == StIdle) ? OKAY : ERROR;
  end

  // State and registered response; reset abandons any partial ERROR.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= StIdle;
      hreadyout_q <= 1'b1;
      hresp_q     <= OKAY;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign def_hreadyout = hreadyout_q;
  assign def_hresp     = hresp_q;

endmodule

// File: rtl/ahb_decoder_dp.sv
// AHB-Lite slave-side decoder with data-phase select register, default slave and
// response mux. Optional address remap enabled by defining AHB_DEC_REMAP_EN.
module ahb_decoder_dp
  import AHB_package::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned SLV_NUM        = 7
`ifdef AHB_DEC_REMAP_EN
  ,
  parameter int unsigned REMAP_SLV      = 1
`endif
) (
  input  logic                                    hclk,
  input  logic                                    hreset_n,
`ifdef AHB_DEC_REMAP_EN
  input  logic                                    hremap,
`endif
  input  logic      [AHB_ADDR_WIDTH-1:0]          haddr,
  input  htrans_type                              htrans,
  output logic      [SLV_NUM-1:0]                 hsel,
  input  logic      [SLV_NUM-1:0]                 hreadyout_s,
  input  hresp_type [SLV_NUM-1:0]                 hresp_s,
  input  logic      [SLV_NUM-1:0][AHB_DATA_WIDTH-1:0] hrdata_s,
  output logic                                    hready,
  output hresp_type                               hresp,
  output logic      [AHB_DATA_WIDTH-1:0]          hrdata
);

  logic [SLV_NUM-1:0] match;
  logic               def_sel;
  logic [SLV_NUM:0]   dp_sel_q, dp_sel_d;
  logic               def_hreadyout;
  hresp_type          def_hresp;

`ifdef AHB_DEC_REMAP_EN
  logic remap_q, remap_d;

  // Remap state only changes when an address phase is accepted.
  always_comb remap_d = hready ? hremap : remap_q;

  // Remap register.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) remap_q <= 1'b0;
    else           remap_q <= remap_d;
  end
`endif

  for (genvar g = 0; g < SLV_NUM; g++) begin : g_match
    logic [AHB_ADDR_WIDTH-1:0] lo, hi;

    // Effective bounds of slave g, with slave 0 and REMAP_SLV swapped while remapped.
    always_comb begin
      lo = SLV_LOW[g][AHB_ADDR_WIDTH-1:0];
      hi = SLV_HIGH[g][AHB_ADDR_WIDTH-1:0];
`ifdef AHB_DEC_REMAP_EN
      if (remap_q) begin
        if (g == 0) begin
          lo = SLV_LOW[REMAP_SLV][AHB_ADDR_WIDTH-1:0];
          hi = SLV_HIGH[REMAP_SLV][AHB_ADDR_WIDTH-1:0];
        end else if (g == REMAP_SLV) begin
          lo = SLV_LOW[0][AHB_ADDR_WIDTH-1:0];
          hi = SLV_HIGH[0][AHB_ADDR_WIDTH-1:0];
        end
      end
`endif
    end

    assign match[g] = (lo <= haddr) && (haddr <= hi);
  end

  // Priority select: walking downward leaves the lowest matching index as the winner.
  always_comb begin
    hsel = '0;
    for (int i = int'(SLV_NUM) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign def_sel = ~|hsel;

  // Data-phase select follows the address phase only when it is accepted.
  always_comb dp_sel_d = hready ? {def_sel, hsel} : dp_sel_q;

  // Data-phase select register; reset points at the default slave.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) dp_sel_q <= {1'b1, {SLV_NUM{1'b0}}};
    else           dp_sel_q <= dp_sel_d;
  end

  ahb_default_slave u_default_slave (
    .hclk          (hclk),
    .hreset_n      (hreset_n),
    .hready        (hready),
    .htrans        (htrans),
    .def_sel       (def_sel),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp)
  );

  // Response mux; the default slave returns zero read data.
  always_comb begin
    hready = def_hreadyout;
    hresp  = def_hresp;
    hrdata = '0;
    for (int i = 0; i < int'(SLV_NUM); i++) begin
      if (dp_sel_q[i]) begin
        hready = hreadyout_s[i];
        hresp  = hresp_s[i];
        hrdata = hrdata_s[i];
      end
    end
  end

endmodule
